// File: rtl/aes128_pkg.sv
// Shared constants, FSM state type, S-box table and GF(2^8) helper for the AES-128 round engine.
package aes128_pkg;

    localparam int BLOCK_W    = 128;
    localparam int NUM_ROUNDS = 10;
    localparam int RND_W      = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } aes_state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Multiply by x in GF(2^8) modulo 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes128_round_engine_if.sv
// Plaintext-in / ciphertext-out valid-ready bundle of the AES-128 round engine.
interface aes128_round_engine_if;
    import aes128_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [BLOCK_W-1:0] in_data;
    logic               out_valid;
    logic               out_ready;
    logic [BLOCK_W-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/aes_round.sv
// One combinational AES round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
module aes_round
    import aes128_pkg::*;
(
    input  logic [BLOCK_W-1:0] state_in,
    input  logic [BLOCK_W-1:0] round_key,
    input  logic               final_round,
    output logic [BLOCK_W-1:0] state_out
);

    logic [7:0] sb [16];
    logic [7:0] sr [16];
    logic [7:0] mc [16];

    // Byte i sits at bits [127-8i -: 8]; byte index is row + 4*column.
    always_comb begin
        sb        = '{default: 8'h00};
        sr        = '{default: 8'h00};
        mc        = '{default: 8'h00};
        state_out = '0;
        for (int i = 0; i < 16; i++) begin
            sb[i] = SBOX[state_in[127-8*i -: 8]];
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[r + 4*c] = sb[r + 4*((c + r) % 4)];
            end
        end
        for (int c = 0; c < 4; c++) begin
            mc[4*c]   = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
            mc[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
        end
        for (int i = 0; i < 16; i++) begin
            state_out[127-8*i -: 8] = (final_round ? sr[i] : mc[i]) ^ round_key[127-8*i -: 8];
        end
    end

endmodule

// File: rtl/aes128_round_engine.sv
// Iterative AES-128 encryptor, one round per clock, fed by precomputed round keys.
// Optional one-entry input buffer enabled by defining AES_INPUT_BUF_EN.
//
// state | meaning
// IDLE  | waiting for plaintext; in_ready follows key_valid
// ROUND | running rounds 1..10, rnd selects the round key
// DONE  | ciphertext held on out_data until out_ready
module aes128_round_engine
    import aes128_pkg::*;
(
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [BLOCK_W-1:0] key_0,
    input  logic [BLOCK_W-1:0] key_1,
    input  logic [BLOCK_W-1:0] key_2,
    input  logic [BLOCK_W-1:0] key_3,
    input  logic [BLOCK_W-1:0] key_4,
    input  logic [BLOCK_W-1:0] key_5,
    input  logic [BLOCK_W-1:0] key_6,
    input  logic [BLOCK_W-1:0] key_7,
    input  logic [BLOCK_W-1:0] key_8,
    input  logic [BLOCK_W-1:0] key_9,
    input  logic [BLOCK_W-1:0] key_10,
    input  logic               key_valid,
    aes128_round_engine_if.slave bus,
    output logic               busy
);

    localparam logic [RND_W-1:0] LAST_RND = RND_W'(NUM_ROUNDS);

    aes_state_t         state, state_nxt;
    logic [RND_W-1:0]   rnd;
    logic [BLOCK_W-1:0] state_reg;
    logic [BLOCK_W-1:0] round_key;
    logic [BLOCK_W-1:0] round_out;
    logic [BLOCK_W-1:0] out_data_q;
    logic               out_valid_q;
    logic               in_rdy;
    logic               accept;
    logic               final_rnd;
    logic               reload;
    logic [BLOCK_W-1:0] start_data;

    assign accept    = bus.in_valid & in_rdy;
    assign final_rnd = (rnd == LAST_RND);

`ifdef AES_INPUT_BUF_EN
    logic               buf_full;
    logic [BLOCK_W-1:0] buf_data;

    // In DONE a pending block (buffered or arriving now) restarts ROUND on the handshake edge.
    assign reload     = buf_full | accept;
    assign start_data = buf_full ? buf_data : bus.in_data;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            buf_full <= 1'b0;
            buf_data <= '0;
        end else if (state == ROUND && !key_valid) begin
            buf_full <= 1'b0;
        end else if (state == DONE && bus.out_ready) begin
            buf_full <= 1'b0;
        end else if (accept && state != IDLE) begin
            buf_full <= 1'b1;
            buf_data <= bus.in_data;
        end
    end
`else
    assign reload     = 1'b0;
    assign start_data = bus.in_data;
`endif

    always_comb begin
        case (rnd)
            4'd1:    round_key = key_1;
            4'd2:    round_key = key_2;
            4'd3:    round_key = key_3;
            4'd4:    round_key = key_4;
            4'd5:    round_key = key_5;
            4'd6:    round_key = key_6;
            4'd7:    round_key = key_7;
            4'd8:    round_key = key_8;
            4'd9:    round_key = key_9;
            default: round_key = key_10;
        endcase
    end

    aes_round u_round (
        .state_in    (state_reg),
        .round_key   (round_key),
        .final_round (final_rnd),
        .state_out   (round_out)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ROUND;
            ROUND: begin
                if (!key_valid)     state_nxt = IDLE;
                else if (final_rnd) state_nxt = DONE;
            end
            DONE:    if (bus.out_ready) state_nxt = reload ? ROUND : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = RST_N & (state != IDLE);
`ifdef AES_INPUT_BUF_EN
        in_rdy = RST_N & key_valid & ~buf_full;
`else
        in_rdy = RST_N & key_valid & (state == IDLE);
`endif
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_reg   <= '0;
            rnd         <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state_reg <= bus.in_data ^ key_0;
                        rnd       <= 4'd1;
                    end
                end
                ROUND: begin
                    if (!key_valid) begin
                        rnd <= '0;
                    end else begin
                        state_reg <= round_out;
                        if (final_rnd) begin
                            out_data_q  <= round_out;
                            out_valid_q <= 1'b1;
                            rnd         <= '0;
                        end else begin
                            rnd <= rnd + 4'd1;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        if (reload) begin
                            state_reg <= start_data ^ key_0;
                            rnd       <= 4'd1;
                        end
                    end
                end
                default: rnd <= '0;
            endcase
        end
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_aes128_round_engine.sv
// Directed FIPS-197 vector bench for aes128_round_engine, including backpressure, abort and reset cases.
module tb_aes128_round_engine;
    import aes128_pkg::*;

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         CLK = 1'b0;
    logic         RST_N;
    logic [127:0] key [11];
    logic         key_valid;
    logic         busy;
    int           n_checks = 0;
    int           n_fail   = 0;

    aes128_round_engine_if bus ();

    aes128_round_engine dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .key_0     (key[0]),
        .key_1     (key[1]),
        .key_2     (key[2]),
        .key_3     (key[3]),
        .key_4     (key[4]),
        .key_5     (key[5]),
        .key_6     (key[6]),
        .key_7     (key[7]),
        .key_8     (key[8]),
        .key_9     (key[9]),
        .key_10    (key[10]),
        .key_valid (key_valid),
        .bus       (bus.slave),
        .busy      (busy)
    );

    initial forever #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Stand-in for the upstream key-schedule stage.
    task automatic load_keys(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {SBOX[t[31:24]], SBOX[t[23:16]], SBOX[t[15:8]], SBOX[t[7:0]]} ^ {rcon, 24'h0};
                rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) key[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!bus.in_ready && n < 30) begin
            @(negedge CLK);
            n++;
        end
        check({tag, "_in_ready"}, 128'(bus.in_ready), 128'd1);
    endtask

    // Returns at the negedge following the accepting edge.
    task automatic send(input logic [127:0] pt);
        bus.in_valid = 1'b1;
        bus.in_data  = pt;
        @(posedge CLK);
        @(negedge CLK);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(inout int lat);
        while (!bus.out_valid && lat < 30) begin
            @(negedge CLK);
            lat++;
        end
    endtask

    task automatic run_block(input string tag, input logic [127:0] pt, input logic [127:0] exp);
        int lat = 0;
        wait_ready(tag);
        send(pt);
        wait_out(lat);
        check({tag, "_latency"}, 128'(lat), 128'd10);
        check({tag, "_data"}, bus.out_data, exp);
        bus.out_ready = 1'b1;
        @(negedge CLK);
        check({tag, "_out_valid_drop"}, 128'(bus.out_valid), 128'd0);
        check({tag, "_busy_drop"}, 128'(busy), 128'd0);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        RST_N        = 1'b0;
        key_valid    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.out_ready = 1'b0;
        load_keys(KEY_B);
        key_valid = 1'b1;
        repeat (2) @(negedge CLK);
        check("rst_in_ready", 128'(bus.in_ready), 128'd0);
        check("rst_out_valid", 128'(bus.out_valid), 128'd0);
        check("rst_out_data", bus.out_data, 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        RST_N = 1'b1;
        @(negedge CLK);
        check("idle_in_ready", 128'(bus.in_ready), 128'd1);

        run_block("app_b", PT_B, CT_B);
        load_keys(KEY_C);
        run_block("app_c", PT_C, CT_C);

        // Backpressure: result must hold while the sink stalls.
        load_keys(KEY_B);
        wait_ready("bp");
        send(PT_B);
        lat = 0;
        wait_out(lat);
        check("bp_latency", 128'(lat), 128'd10);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check("bp_out_valid", 128'(bus.out_valid), 128'd1);
            check("bp_out_data", bus.out_data, CT_B);
            check("bp_busy", 128'(busy), 128'd1);
`ifndef AES_INPUT_BUF_EN
            check("bp_in_ready", 128'(bus.in_ready), 128'd0);
`endif
        end
        bus.out_ready = 1'b1;
        @(negedge CLK);
        check("bp_out_valid_drop", 128'(bus.out_valid), 128'd0);
        check("bp_idle_in_ready", 128'(bus.in_ready), 128'd1);
        bus.out_ready = 1'b0;

        // Abort when key_valid drops at round 4.
        send(PT_B);
        repeat (3) @(negedge CLK);
        key_valid = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(negedge CLK);
            check("abort_out_valid", 128'(bus.out_valid), 128'd0);
            check("abort_in_ready", 128'(bus.in_ready), 128'd0);
        end
        check("abort_busy", 128'(busy), 128'd0);
        key_valid = 1'b1;
        run_block("after_abort", PT_B, CT_B);

        // Synchronous reset at round 6; previous out_data was nonzero.
        load_keys(KEY_C);
        wait_ready("rst_mid");
        send(PT_C);
        repeat (5) @(negedge CLK);
        RST_N = 1'b0;
        @(negedge CLK);
        check("rst_mid_out_valid", 128'(bus.out_valid), 128'd0);
        check("rst_mid_out_data", bus.out_data, 128'd0);
        check("rst_mid_busy", 128'(busy), 128'd0);
        check("rst_mid_in_ready", 128'(bus.in_ready), 128'd0);
        RST_N = 1'b1;
        @(negedge CLK);
        run_block("after_rst", PT_C, CT_C);

`ifdef AES_INPUT_BUF_EN
        // Back-to-back with buffer: keys switch during DONE, before the reload edge.
        load_keys(KEY_B);
        wait_ready("buf");
        send(PT_B);
        check("buf_in_ready_round", 128'(bus.in_ready), 128'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = PT_C;
        @(posedge CLK);
        @(negedge CLK);
        bus.in_valid = 1'b0;
        lat = 1;
        wait_out(lat);
        check("buf_first_latency", 128'(lat), 128'd10);
        check("buf_first_data", bus.out_data, CT_B);
        load_keys(KEY_C);
        bus.out_ready = 1'b1;
        lat = 0;
        do begin
            @(negedge CLK);
            lat++;
        end while (!bus.out_valid && lat < 30);
        check("buf_second_gap", 128'(lat), 128'd11);
        check("buf_second_data", bus.out_data, CT_C);
        @(negedge CLK);
        check("buf_out_valid_drop", 128'(bus.out_valid), 128'd0);
        bus.out_ready = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aes128_round_engine.md
Name: aes128_round_engine

Overview:
Iterative AES-128 encryption datapath that sits directly downstream of the key-schedule stage. It consumes the eleven registered round keys key_0..key_10 and encrypts one 128-bit plaintext block per transaction, executing one full round per clock. Input and output use valid/ready handshakes, and the result feeds the system's ciphertext sink.

Parameters:
NUM_ROUNDS, 10, number of AES rounds; fixed at 10 for AES-128, other values unsupported.
BLOCK_W, 128, data and key width in bits.

Ports:
CLK  input  1  system clock, rising edge.
RST_N  input  1  synchronous, active-low reset.
key_0..key_10  input  128 each  round keys from the key-schedule stage; must be stable while busy.
key_valid  input  1  round keys are valid for the current cipher key.
in_valid  input  1  plaintext present.
in_ready  output  1  engine can accept plaintext.
in_data  input  128  plaintext; bit 127 is FIPS-197 byte 0; state is column-major.
out_valid  output  1  ciphertext present.
out_ready  input  1  sink accepts ciphertext.
out_data  output  128  ciphertext, same byte order as in_data.
busy  output  1  high in ROUND or DONE.

Behaviour:
- Reset (RST_N=0 at a rising edge):
  - state goes to IDLE; round counter = 0; state register = 0.
  - out_valid=0, out_data=0, in_ready=0 during reset, busy=0.
  - Reset has priority over every other event, including mid-block; an in-flight block is discarded.
- FSM states are IDLE, ROUND and DONE.
- IDLE:
  - in_ready = key_valid.
  - On in_valid & in_ready: state_reg <= in_data ^ key_0; rnd <= 1; go to ROUND.
- ROUND:
  - Each cycle, state_reg <= round(state_reg) ^ key_rnd, where key_rnd is selected by a 4-bit counter.
  - round = SubBytes, ShiftRows, MixColumns for rnd 1..9. MixColumns is skipped when rnd = 10.
  - At rnd = 10: out_data <= result; out_valid <= 1; go to DONE. Otherwise rnd <= rnd + 1.
- DONE:
  - out_valid and out_data are held stable until out_ready.
  - On out_valid & out_ready: out_valid <= 0; go to IDLE.
- Latency: out_valid rises exactly 10 cycles after the accepting edge.
- Throughput: without the optional feature, a new block is accepted at best 12 cycles after the previous one: 10 ROUND cycles, 1 DONE cycle with out_ready=1, then 1 IDLE cycle.
- key_valid falling while in ROUND aborts the block: go to IDLE, no out_valid, rnd <= 0. key_valid falling in DONE has no effect; the completed result is still delivered.
- in_valid held in ROUND/DONE is ignored (in_ready=0); no data is lost, because the upstream must hold it.
- GF(2^8) arithmetic uses reduction polynomial 0x11B. xtime is byte<<1 XOR (0x1B if the MSB was set).
- The S-box is combinational: 16 parallel lookups per cycle.

Optional Feature:
Macro AES_INPUT_BUF_EN.
- Defined: adds a one-entry input buffer.
  - in_ready = key_valid & buffer empty in any state.
  - In IDLE, an accepted block starts directly.
  - In ROUND/DONE, an accepted block is stored.
  - On the DONE handshake edge with the buffer full, the engine loads buf ^ key_0 and goes straight to ROUND, skipping IDLE. Sustained rate is one block per 11 cycles.
  - An abort or reset clears the buffer.
- Undefined: no buffer; in_ready is high only in IDLE, as above.

Decomposition:
- Package aes128_pkg:
  - S-box constant array (256 x 8).
  - FSM state typedef (IDLE/ROUND/DONE).
  - Round-counter width constant (4).
  - xtime function.
- One sub-module, aes_round: a combinational single round with inputs state_in, round_key and final_round, and output state_out.

Test Plan:
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c (round keys driven from the key-schedule stage), pt 3243f6a8885a308d313198a2e0370734 -> out_data 3925841d02dc09fbdc118597196a0b32, 10 cycles after acceptance.
- FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> 69c4e0d86a7b0430d8cdb78070b4c55a.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out_valid/out_data stable, in_ready=0 (macro off); out_ready=1 -> IDLE next cycle.
- Abort: deassert key_valid at round 4 -> no out_valid, in_ready=0 until key_valid=1, then the App. B vector encrypts correctly.
- Reset mid-block: RST_N=0 at round 6 -> all outputs 0 on the next edge; the following block produces the correct ciphertext.
- AES_INPUT_BUF_EN: present App. B and App. C.1 blocks back-to-back with out_ready=1 -> both correct, in order, second out_valid 11 cycles after the first.
